// File: rtl/summ_pipe.sv
// summ_pipe: masked signed delay-and-sum over a registered binary adder tree; SUMM_PIPE_SAT_EN selects clamping instead of wrap
module summ_pipe #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int OUT_WIDTH    = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] din,
  input  logic [NUM_CHANNELS-1:0]            ch_mask,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [OUT_WIDTH-1:0]               sout,
  output logic                               out_valid,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               sat_hit
);
  localparam int L  = $clog2(NUM_CHANNELS);
  localparam int FW = DATA_WIDTH + L;
  function automatic int cnt(input int s);
    return (NUM_CHANNELS + (1 << s) - 1) >> s;
  endfunction
  logic                 w_adv;
  logic                 r_init;
  logic signed [FW-1:0] w_full;
  logic [OUT_WIDTH-1:0] w_out;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && r_init;
  // input acceptance opens on the first edge after reset release
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_init <= 1'b0;
    else r_init <= 1'b1;
  genvar s, i;
  for (s = 0; s < L; s++) begin : g_lvl
    localparam int N = cnt(s);
    logic signed [FW-1:0] r_d [N];
    logic signed [FW-1:0] w_d [N];
    logic                 r_v, r_l, w_v, w_l;
    if (s == 0) begin : g_in
      for (i = 0; i < N; i++) begin : g_ch
        assign w_d[i] = ch_mask[i] ? {{L{din[i*DATA_WIDTH+DATA_WIDTH-1]}}, din[i*DATA_WIDTH +: DATA_WIDTH]} : '0;
      end
      assign w_v = in_valid && in_ready;
      assign w_l = in_last && in_valid && in_ready;
    end else begin : g_add
      localparam int P = cnt(s - 1);
      for (i = 0; i < N; i++) begin : g_pair
        if (2 * i + 1 < P) begin : g_sum
          assign w_d[i] = g_lvl[s-1].r_d[2*i] + g_lvl[s-1].r_d[2*i+1];
        end else begin : g_pass
          assign w_d[i] = g_lvl[s-1].r_d[2*i];
        end
      end
      assign w_v = g_lvl[s-1].r_v;
      assign w_l = g_lvl[s-1].r_l;
    end
    // each tree level freezes as a unit while the output is stalled
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_v <= 1'b0;
        r_l <= 1'b0;
        r_d <= '{default: '0};
      end else if (w_adv) begin
        r_v <= w_v;
        r_l <= w_l;
        r_d <= w_d;
      end
  end
  assign w_full = g_lvl[L-1].r_d[0] + g_lvl[L-1].r_d[1];
`ifdef SUMM_PIPE_SAT_EN
  logic w_clip, r_clip, r_sat;
`endif
  if (OUT_WIDTH >= FW) begin : g_ext
    assign w_out = OUT_WIDTH'(w_full);
`ifdef SUMM_PIPE_SAT_EN
    assign w_clip = 1'b0;
`endif
  end else begin : g_red
`ifdef SUMM_PIPE_SAT_EN
    logic [FW-OUT_WIDTH:0] w_top;
    assign w_top  = w_full[FW-1:OUT_WIDTH-1];
    assign w_clip = !(&w_top) && |w_top;
    assign w_out  = w_clip ? {w_full[FW-1], {(OUT_WIDTH-1){!w_full[FW-1]}}} : w_full[OUT_WIDTH-1:0];
`else
    assign w_out = w_full[OUT_WIDTH-1:0];
`endif
  end
  // final adder and width adjust; sout only reloads for a valid sample
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sout      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (w_adv) begin
      out_valid <= g_lvl[L-1].r_v;
      out_last  <= g_lvl[L-1].r_l;
      if (g_lvl[L-1].r_v) sout <= w_out;
    end
`ifdef SUMM_PIPE_SAT_EN
  // clamp tag travels with sout; sticky flag sets when a clamped sample is taken
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_clip <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      if (w_adv && g_lvl[L-1].r_v) r_clip <= w_clip;
      r_sat <= r_sat || (out_valid && out_ready && r_clip);
    end
  assign sat_hit = r_sat;
`else
  assign sat_hit = 1'b0;
`endif
endmodule

// File: tb/tb_summ_pipe.sv
// tb_summ_pipe: directed-vector bench for summ_pipe (4-channel/24-bit and 5-channel/16-bit instances)
module tb_summ_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] din = '0;
  logic [3:0]  ch_mask = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [23:0] sout;
  logic        out_valid, out_last, out_ready = 1'b1, sat_hit;
  logic [79:0] din5 = '0;
  logic [4:0]  mask5 = '0;
  logic        iv5 = 1'b0, il5 = 1'b0, ir5;
  logic [15:0] sout5;
  logic        ov5, ol5, or5 = 1'b1, sh5;
  int          vecs = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  summ_pipe #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .OUT_WIDTH(24)) u_dut (
    .clk(clk), .reset(reset), .din(din), .ch_mask(ch_mask), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sout(sout), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .sat_hit(sat_hit));
  summ_pipe #(.DATA_WIDTH(16), .NUM_CHANNELS(5), .OUT_WIDTH(16)) u_dut5 (
    .clk(clk), .reset(reset), .din(din5), .ch_mask(mask5), .in_valid(iv5), .in_last(il5),
    .in_ready(ir5), .sout(sout5), .out_valid(ov5), .out_last(ol5), .out_ready(or5),
    .sat_hit(sh5));
  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) step;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    vecs++; if (sout !== 24'h0) begin errs++; $display("FAIL rst_sout: got %h exp 000000", sout); end
    vecs++; if (out_last !== 1'b0) begin errs++; $display("FAIL rst_out_last: got %b exp 0", out_last); end
    vecs++; if (sat_hit !== 1'b0) begin errs++; $display("FAIL rst_sat_hit: got %b exp 0", sat_hit); end
    vecs++; if (ov5 !== 1'b0 || sh5 !== 1'b0) begin errs++; $display("FAIL rst_dut5: got valid %b sat %b exp 0 0", ov5, sh5); end
    reset = 1'b1;
    step;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
  endtask
  task automatic test_basic;
    out_ready = 1'b1;
    din = pack4(1, 2, 3, 4);
    ch_mask = 4'hF;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lat_edge1: got %b exp 0", out_valid); end
    step;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lat_edge2: got %b exp 0", out_valid); end
    step;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL lat_edge3: got %b exp 1", out_valid); end
    vecs++; if ($signed(sout) !== 10) begin errs++; $display("FAIL basic_sum: got %0d exp 10", $signed(sout)); end
    step;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_drain: got %b exp 0", out_valid); end
  endtask
  task automatic test_mask;
    din = pack4(-100, 50, -25, 5);
    ch_mask = 4'b0101;
    in_valid = 1'b1;
    step;
    ch_mask = 4'b0000;
    step;
    in_valid = 1'b0;
    ch_mask = 4'hF;
    step;
    vecs++; if (out_valid !== 1'b1 || $signed(sout) !== -125) begin errs++; $display("FAIL mask_0101: got v%b %0d exp v1 -125", out_valid, $signed(sout)); end
    step;
    vecs++; if (out_valid !== 1'b1 || $signed(sout) !== 0) begin errs++; $display("FAIL mask_zero: got v%b %0d exp v1 0", out_valid, $signed(sout)); end
    step;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mask_drain: got %b exp 0", out_valid); end
  endtask
  task automatic test_back_to_back;
    int j = 0, got = 0, cyc = 0, extra = 0;
    logic acc;
    ch_mask = 4'hF;
    while (got < 8 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid = (j < 8);
      din = pack4(j + 1, 10 * (j + 1), -3, 7);
      in_last = (j == 7);
      #1;
      vecs++; if (in_ready !== !(out_valid && !out_ready)) begin errs++; $display("FAIL b2b_in_ready cyc %0d: got %b exp %b", cyc, in_ready, !(out_valid && !out_ready)); end
      if (out_valid && out_ready) begin
        vecs++; if ($signed(sout) !== (got + 1) + 10 * (got + 1) - 3 + 7) begin errs++; $display("FAIL b2b_sum %0d: got %0d exp %0d", got, $signed(sout), (got + 1) + 10 * (got + 1) + 4); end
        vecs++; if (out_last !== (got == 7)) begin errs++; $display("FAIL b2b_last %0d: got %b exp %b", got, out_last, got == 7); end
        got++;
      end
      acc = in_valid && in_ready;
      step;
      if (acc) j++;
      cyc++;
    end
    vecs++; if (got !== 8) begin errs++; $display("FAIL b2b_count: got %0d exp 8", got); end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      if (out_valid) extra++;
      step;
    end
    vecs++; if (extra !== 0) begin errs++; $display("FAIL b2b_dup: got %0d extra exp 0", extra); end
  endtask
  task automatic test_sat;
    int k = 0;
    logic [15:0] exp_s;
    logic        exp_h;
`ifdef SUMM_PIPE_SAT_EN
    exp_s = 16'h7FFF;
    exp_h = 1'b1;
`else
    exp_s = 16'h7FFB;
    exp_h = 1'b0;
`endif
    din5 = {5{16'h7FFF}};
    mask5 = 5'h1F;
    or5 = 1'b1;
    iv5 = 1'b1;
    step;
    iv5 = 1'b0;
    while (!ov5 && k < 10) begin
      step;
      k++;
    end
    vecs++; if (ov5 !== 1'b1) begin errs++; $display("FAIL sat_valid: got %b exp 1", ov5); end
    vecs++; if (sout5 !== exp_s) begin errs++; $display("FAIL sat_sout: got %h exp %h", sout5, exp_s); end
    vecs++; if (sh5 !== 1'b0) begin errs++; $display("FAIL sat_pre_flag: got %b exp 0", sh5); end
    step;
    vecs++; if (sh5 !== exp_h) begin errs++; $display("FAIL sat_flag: got %b exp %b", sh5, exp_h); end
    step;
    vecs++; if (sh5 !== exp_h) begin errs++; $display("FAIL sat_sticky: got %b exp %b", sh5, exp_h); end
  endtask
  task automatic test_reset_flight;
    int seen = 0;
    out_ready = 1'b1;
    ch_mask = 4'hF;
    in_valid = 1'b1;
    din = pack4(1, 1, 1, 1);
    step;
    din = pack4(2, 2, 2, 2);
    step;
    din = pack4(3, 3, 3, 3);
    in_last = 1'b1;
    step;
    in_valid = 1'b0;
    in_last = 1'b0;
    vecs++; if (out_valid !== 1'b1 || $signed(sout) !== 4) begin errs++; $display("FAIL flight_first: got v%b %0d exp v1 4", out_valid, $signed(sout)); end
    #1 reset = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flight_async: got %b exp 0", out_valid); end
    vecs++; if (sout !== 24'h0) begin errs++; $display("FAIL flight_sout: got %h exp 000000", sout); end
    step;
    reset = 1'b1;
    repeat (8) begin
      if (out_valid || out_last) seen++;
      step;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL flight_stale: got %0d exp 0", seen); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flight_ready: got %b exp 1", in_ready); end
  endtask
  task automatic test_bubbles;
    int n = 0;
    int at [2];
    int val [2];
    out_ready = 1'b1;
    ch_mask = 4'hF;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 4) && (c % 2 == 0);
      din = (c == 0) ? pack4(3, 4, 5, 6) : pack4(-1, -2, -3, -4);
      if (out_valid && out_ready) begin
        if (n < 2) begin
          at[n] = c;
          val[n] = $signed(sout);
        end
        n++;
      end
      step;
    end
    in_valid = 1'b0;
    vecs++; if (n !== 2) begin errs++; $display("FAIL bub_count: got %0d exp 2", n); end
    if (n >= 2) begin
      vecs++; if (at[1] - at[0] !== 2) begin errs++; $display("FAIL bub_gap: got %0d exp 2", at[1] - at[0]); end
      vecs++; if (val[0] !== 18 || val[1] !== -10) begin errs++; $display("FAIL bub_vals: got %0d %0d exp 18 -10", val[0], val[1]); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_mask;
    test_back_to_back;
    test_sat;
    test_reset_flight;
    test_bubbles;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
